// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS countdown timer with load/start/stop control and expiry pulse
module countdown_timer #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] MM,
  output logic [5:0] SS,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

  state_t      state;
  logic [25:0] presc;
  logic        tick;
  logic        at_zero;
  logic        last_sec;
  logic        pause_req;

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  assign tick      = (presc == TICK_LAST);
  assign at_zero   = (MM == 6'd0) && (SS == 6'd0);
  assign last_sec  = (MM == 6'd0) && (SS == 6'd1);
  // start outranks stop, so a start held alongside stop keeps the count running
  assign pause_req = stop && !start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      MM      <= 6'd0;
      SS      <= 6'd0;
      presc   <= 26'd0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state   <= IDLE;
        MM      <= clamp59(load_mm);
        SS      <= clamp59(load_ss);
        presc   <= 26'd0;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            presc <= 26'd0;
            if (start && !at_zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              presc <= 26'd0;
              if (last_sec) begin
                // terminal tick beats a concurrent stop
                SS      <= 6'd0;
                state   <= EXPIRED;
                running <= 1'b0;
                expired <= 1'b1;
                done    <= 1'b1;
              end else begin
                if (SS != 6'd0) begin
                  SS <= SS - 6'd1;
                end else begin
                  MM <= MM - 6'd1;
                  SS <= 6'd59;
                end
                if (pause_req) begin
                  state   <= PAUSE;
                  running <= 1'b0;
                end
              end
            end else if (pause_req) begin
              presc   <= 26'd0;
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              presc <= presc + 26'd1;
            end
          end
          EXPIRED: begin
            presc <= 26'd0;
            MM    <= 6'd0;
            SS    <= 6'd0;
          end
          default: begin
            state   <= IDLE;
            presc   <= 26'd0;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
